// File: rtl/serial_slave_port.sv
// Slave endpoint of the serial bus: bit-serial address/data in, register bank, bit-serial read-back.
// Optional idle-abort logic is compiled in with SERIAL_SLAVE_TIMEOUT_EN.
module serial_slave_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic master_valid,
    input  logic master_ready,
    input  logic rx_address,
    input  logic rx_data,
    input  logic write_en,
    input  logic read_en,
    output logic tx_data,
    output logic slave_valid,
    output logic slave_ready,
    output logic err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(MAXW) + 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLOAD, RDATA} state_t;

    state_t                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wsh_q, wsh_d;
    logic [DATA_WIDTH-1:0]  tsh_q, tsh_d;
    logic [DATA_WIDTH-1:0]  bank_q [DEPTH];
    logic                   bank_we;
    logic                   abort;

`ifdef SERIAL_SLAVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          stalled;

    // Any progress (or leaving the stalling states) restarts the idle count.
    always_comb begin
        stalled = 1'b0;
        case (state_q)
            ADDR, WDATA: stalled = !master_valid;
            RDATA:       stalled = !master_ready;
            default:     stalled = 1'b0;
        endcase
        abort  = stalled && (idle_q == IDLE_LAST);
        idle_d = (stalled && !abort) ? idle_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_q <= '0;
        else      idle_q <= idle_d;
    end

    assign err = abort;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wsh_d   = wsh_q;
        tsh_d   = tsh_q;
        bank_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (master_valid && (write_en ^ read_en)) begin
                    wr_d    = write_en;
                    addr_d  = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d   = CW'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (master_valid) begin
                    addr_d = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = wr_q ? WDATA : RLOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (master_valid) begin
                    wsh_d = {rx_data, wsh_q[DATA_WIDTH-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        bank_we = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RLOAD: begin
                tsh_d   = bank_q[addr_q];
                state_d = RDATA;
            end
            RDATA: begin
                if (master_ready) begin
                    tsh_d = tsh_q >> 1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            bank_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wsh_q   <= '0;
            tsh_q   <= '0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wsh_q   <= wsh_d;
            tsh_q   <= tsh_d;
            if (bank_we) bank_q[addr_q] <= wsh_d;
        end
    end

    assign slave_ready = (state_q == IDLE);
    assign slave_valid = (state_q == RDATA);
    assign tx_data     = slave_valid & tsh_q[0];

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Slave-side endpoint of the serial system bus. Accepts the bit-serial address/data stream that the bus mux routes from the granted master.
- Writes into a local register bank, or returns read data bit-serially to the master.
- Instantiated once per slave (s1..s3) behind the bus mux; the counterpart of the master-side serial port.

Parameters:
- ADDR_WIDTH, 4, address bits per transaction (>=2); bank depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data bits per word (>=2).
- TIMEOUT, 16, idle-cycle limit used only with SERIAL_SLAVE_TIMEOUT_EN.

Ports:
- clk  in  1  slave clock.
- rst  in  1  asynchronous, active-low reset.
- master_valid  in  1  master is driving a valid rx_address/rx_data bit this cycle.
- master_ready  in  1  master accepts the current tx_data bit this cycle.
- rx_address  in  1  serial address bit, LSB first.
- rx_data  in  1  serial write-data bit, LSB first.
- write_en  in  1  write command, sampled at transaction start.
- read_en  in  1  read command, sampled at transaction start.
- tx_data  out  1  serial read-data bit, LSB first.
- slave_valid  out  1  tx_data holds a valid read bit.
- slave_ready  out  1  slave is idle and accepts a new transaction.
- err  out  1  one-cycle abort pulse (timeout feature only).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all bank words, shift registers and counters cleared to 0.
  - slave_ready=1, slave_valid=0, tx_data=0, err=0.
- IDLE:
  - slave_ready=1.
  - Start condition: master_valid=1 with exactly one of write_en/read_en high. On that edge: latch command, capture rx_address as address bit 0, bit count=1, go to ADDR.
  - master_valid=1 with both enables high or both low: ignored, stay IDLE, no state change.
- ADDR:
  - slave_ready=0.
  - Each edge with master_valid=1 shifts in one address bit. master_valid=0 stalls; no capture, count held.
  - When bit ADDR_WIDTH-1 is captured: write command → WDATA (count=0); read command → RLOAD.
- WDATA:
  - Each edge with master_valid=1 captures one rx_data bit, LSB first.
  - On the edge capturing bit DATA_WIDTH-1, the full word is written to bank[addr] on that same edge; go to IDLE. slave_ready=1 in the next cycle.
- RLOAD: one cycle. On its edge, load the tx shift register from bank[addr]; go to RDATA.
- RDATA:
  - slave_valid=1; tx_data = shift[0].
  - Each edge with master_ready=1 shifts right and increments the count. master_ready=0 holds tx_data and slave_valid.
  - After DATA_WIDTH accepted bits → IDLE. slave_valid=0 and tx_data=0 from the next cycle.
- Latency:
  - Read: slave_valid rises 2 cycles after the edge capturing the last address bit.
  - Write: data is visible to any transaction starting after the slave returns to IDLE.
- Inputs while not in IDLE: write_en/read_en changes are ignored mid-transaction. rx_address is ignored outside IDLE/ADDR; rx_data is ignored outside WDATA.
- Counters: bit counter width = clog2(max(ADDR_WIDTH,DATA_WIDTH))+1; it never wraps, because every state exit resets it.
- Reset mid-transaction: immediate return to IDLE. A partial write is discarded, and the bank is cleared by reset.

Optional Feature:
- Macro: SERIAL_SLAVE_TIMEOUT_EN.
- Defined: an idle counter runs in ADDR/WDATA while master_valid=0 and in RDATA while master_ready=0. It clears on any progress. On reaching TIMEOUT consecutive idle cycles, go to IDLE without writing, pulse err=1 for one cycle, and clear slave_valid.
- Undefined: no counter; the slave stalls indefinitely; err is tied to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles → slave_ready=1, slave_valid=0, tx_data=0, err=0; a read of any address returns 0x00.
- Write 0xA5 to addr 0x3, then read addr 0x3 → after the 4 address bits, slave_valid is high 2 cycles later; tx_data sequence is 1,0,1,0,0,1,0,1; slave_ready returns to 1.
- Drop master_valid for 3 cycles between address bits 1 and 2 of a write of 0x3C to addr 0xE → read of 0xE returns 0x3C.
- Read with master_ready low for 4 cycles after bit 2 → tx_data and slave_valid hold; full word returned intact, no bit skipped or repeated.
- master_valid=1 with write_en=read_en=1, then with write_en=read_en=0 → slave_ready stays 1 and no bank word changes.
- With SERIAL_SLAVE_TIMEOUT_EN and TIMEOUT=16: stop master_valid after 5 data bits of a write → err pulses on idle cycle 16, slave_ready=1 next cycle, and the target word is unchanged.
